// File: rtl/activation_packer_pkg.sv
// Layer-wide activation types shared by the packer and the neuron arrays.
//   ACT_W     : bit width of one activation element
//   N_ACT     : elements per activation vector (neuron fan-in)
//   act_t     : one signed activation element
//   act_vec_t : one full activation vector, element i at bits [i*ACT_W +: ACT_W]
package activation_packer_pkg;

  localparam int unsigned ACT_W = 8;
  localparam int unsigned N_ACT = 128;

  typedef logic signed [ACT_W-1:0] act_t;
  typedef act_t [N_ACT-1:0]        act_vec_t;

endpackage

// File: rtl/activation_packer_act_bank.sv
// One activation vector of storage: N_ACT x WIDTH_IN registers with a single
// indexed write port and a full-width read of the whole vector.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset (clears storage)
//   we       : write enable
//   widx     : element index written when we=1
//   wdata    : element value, stored bit-exact
//   rdata    : whole vector, element i at bits [i*WIDTH_IN +: WIDTH_IN]
module activation_packer_act_bank
  import activation_packer_pkg::*;
#(
  parameter int unsigned WIDTH_IN = ACT_W,
  parameter int unsigned N_ACT    = activation_packer_pkg::N_ACT,
  localparam int unsigned IdxW    = $clog2(N_ACT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [IdxW-1:0]              widx,
  input  logic [WIDTH_IN-1:0]          wdata,
  output logic [N_ACT*WIDTH_IN-1:0]    rdata
);

  logic [N_ACT-1:0][WIDTH_IN-1:0] mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q;

endmodule

// File: rtl/activation_packer.sv
// Collects the serial stream of neuron results into full activation vectors
// using a ping-pong pair of banks: one bank fills while the other waits for
// the downstream layer.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : in_data holds a neuron result
//   in_ready   : packer accepts in_data this cycle (from registered flags only)
//   in_data    : signed neuron result, stored bit-exact
//   clr        : synchronous abort of the partially filled vector
//   out_valid  : out_vector holds a complete vector
//   out_ready  : downstream takes out_vector this cycle
//   out_vector : complete vector, element i = i-th accepted beat
//   fill_level : elements written into the current write bank
//   banks_full : number of complete banks held (0..2)
module activation_packer
  import activation_packer_pkg::*;
#(
  parameter int unsigned WIDTH_IN = ACT_W,
  parameter int unsigned N_ACT    = activation_packer_pkg::N_ACT,
  localparam int unsigned PtrW    = $clog2(N_ACT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [WIDTH_IN-1:0]       in_data,
  input  logic                             clr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_ACT*WIDTH_IN-1:0]        out_vector,
  output logic [PtrW-1:0]                  fill_level,
  output logic [1:0]                       banks_full
);

  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]      full_q, full_d;

  logic            in_acc;
  logic            wr_en;
  logic            complete;
  logic            out_acc;
  logic [1:0]      bank_we;

  logic [N_ACT*WIDTH_IN-1:0] rdata0, rdata1;

  assign in_ready = ~full_q[wr_bank_q];
  assign in_acc   = in_valid & in_ready;
  // clr wins over a coincident beat, including the completing one.
  assign wr_en    = in_acc & ~clr;
  assign complete = wr_en & (wr_ptr_q == PtrW'(N_ACT - 1));

  assign out_valid = full_q[rd_bank_q];
  assign out_acc   = out_valid & out_ready;

  assign bank_we[0] = wr_en & ~wr_bank_q;
  assign bank_we[1] = wr_en &  wr_bank_q;

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    full_d    = full_q;

    // A completing write needs its bank empty and an output accept needs its
    // bank full, so both can touch full_d in one cycle without colliding.
    if (out_acc) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (clr) begin
      wr_ptr_d = '0;
    end else if (complete) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      wr_ptr_d          = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      full_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      full_q    <= full_d;
    end
  end

  activation_packer_act_bank #(
    .WIDTH_IN (WIDTH_IN),
    .N_ACT    (N_ACT)
  ) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we[0]),
    .widx  (wr_ptr_q),
    .wdata (in_data),
    .rdata (rdata0)
  );

  activation_packer_act_bank #(
    .WIDTH_IN (WIDTH_IN),
    .N_ACT    (N_ACT)
  ) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we[1]),
    .widx  (wr_ptr_q),
    .wdata (in_data),
    .rdata (rdata1)
  );

  assign out_vector = rd_bank_q ? rdata1 : rdata0;
  assign fill_level = wr_ptr_q;
  assign banks_full = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule
